// File: rtl/iob_clint_arbiter_pkg.sv
// Shared definitions for the CLINT IOb arbiter: FSM state encodings,
// the grant-index width helper and the default read-timeout limit.
package iob_clint_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int gnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_clint_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// searching last+1, last+2, ... modulo N. Reusable by other IOb arbiters.
module iob_clint_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Rotating priority search; the first hit after the previous winner wins.
    always_comb begin
        int k;
        k   = 0;
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last) + i) % N;
            if (!any && req[k]) begin
                any = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing the single CLINT IOb slave port among N_REQ
// requesters, one outstanding transaction at a time. The grant is held from
// acceptance until the write handshake or the read rvalid.
// Optional read timeout enabled by defining IOB_CLINT_ARB_TIMEOUT_EN.
module iob_clint_arbiter
    import iob_clint_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [N_REQ-1:0]           req_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           req_rvalid_o,
    output logic [DATA_W-1:0]          req_rdata_o,
    output logic                       m_avalid_o,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic [DATA_W/8-1:0]        m_wstrb_o,
    input  logic                       m_ready_i,
    input  logic                       m_rvalid_i,
    input  logic [DATA_W-1:0]          m_rdata_i,
    output logic                       err_o
);

    localparam int GNT_W  = gnt_width(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("iob_clint_arbiter: N_REQ must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("iob_clint_arbiter: TIMEOUT_CYCLES must be in 2..256");
    end

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   gnt_q, gnt_d;
    logic [GNT_W-1:0]   last_q, last_d;
    logic [GNT_W-1:0]   pick_idx;
    logic               pick_any;

    logic               sel_avalid;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;
    logic               rd_err;

    iob_clint_rr_pick #(
        .N     (N_REQ),
        .IDX_W (GNT_W)
    ) u_pick (
        .req  (req_avalid_i),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign sel_avalid = req_avalid_i[gnt_q];
    assign sel_addr   = req_addr_i[gnt_q*ADDR_W +: ADDR_W];
    assign sel_wdata  = req_wdata_i[gnt_q*DATA_W +: DATA_W];
    assign sel_wstrb  = req_wstrb_i[gnt_q*STRB_W +: STRB_W];

`ifdef IOB_CLINT_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       to_hit;

    assign to_hit = (state_q == WAIT_R) && (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    // A real rvalid in the same cycle wins over the timeout.
    assign rd_err = to_hit && !m_rvalid_i;

    // Read-wait counter: cleared on entry to WAIT_R, counts while waiting.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            to_cnt_q <= '0;
        end else if (state_d == WAIT_R && state_q != WAIT_R) begin
            to_cnt_q <= '0;
        end else if (state_q == WAIT_R) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end
`else
    assign rd_err = 1'b0;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GNT_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic and all slave/master-side outputs.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        req_ready_o  = '0;
        req_rvalid_o = '0;
        req_rdata_o  = rd_err ? '0 : m_rdata_i;
        m_avalid_o   = 1'b0;
        m_addr_o     = '0;
        m_wdata_o    = '0;
        m_wstrb_o    = '0;
        err_o        = rd_err;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_avalid_o         = sel_avalid;
                m_addr_o           = sel_addr;
                m_wdata_o          = sel_wdata;
                m_wstrb_o          = sel_wstrb;
                req_ready_o[gnt_q] = m_ready_i;
                if (!sel_avalid) begin
                    // Requester abandoned before the handshake: pointer untouched.
                    state_d = IDLE;
                end else if (m_ready_i) begin
                    last_d  = gnt_q;
                    state_d = (|sel_wstrb) ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (m_rvalid_i || rd_err) begin
                    req_rvalid_o[gnt_q] = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_clint_arbiter.sv
// Directed self-checking bench for iob_clint_arbiter (N_REQ=2).
module tb_iob_clint_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic                      clk;
    logic                      arst;
    logic [N_REQ-1:0]          req_avalid;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ*STRB_W-1:0]   req_wstrb;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          req_rvalid;
    logic [DATA_W-1:0]         req_rdata;
    logic                      m_avalid;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [STRB_W-1:0]         m_wstrb;
    logic                      m_ready;
    logic                      m_rvalid;
    logic [DATA_W-1:0]         m_rdata;
    logic                      err;

    int n_tests = 0;
    int n_fail  = 0;

    iob_clint_arbiter #(
        .N_REQ          (N_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_avalid_i (req_avalid),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .req_ready_o  (req_ready),
        .req_rvalid_o (req_rvalid),
        .req_rdata_o  (req_rdata),
        .m_avalid_o   (m_avalid),
        .m_addr_o     (m_addr),
        .m_wdata_o    (m_wdata),
        .m_wstrb_o    (m_wstrb),
        .m_ready_i    (m_ready),
        .m_rvalid_i   (m_rvalid),
        .m_rdata_i    (m_rdata),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled mid-cycle, well away from either clock edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit seen;
        arst       = 1'b1;
        req_avalid = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        m_ready    = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
        #1;
        check("rst_avalid", m_avalid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rvalid", req_rvalid, 0);
        check("rst_err", err, 0);
        tick();
        tick();
        arst = 1'b0;

        // Single write from requester 0
        req_addr[0*ADDR_W +: ADDR_W]  = 16'h4000;
        req_wdata[0*DATA_W +: DATA_W] = 32'h0000_0100;
        req_wstrb[0*STRB_W +: STRB_W] = 4'hF;
        req_avalid = 2'b01;
        m_ready    = 1'b1;
        #1;
        check("wr_idle_avalid", m_avalid, 0);
        check("wr_idle_ready", req_ready, 2'b00);
        tick();
        check("wr_avalid", m_avalid, 1);
        check("wr_addr", m_addr, 16'h4000);
        check("wr_wdata", m_wdata, 32'h0000_0100);
        check("wr_wstrb", m_wstrb, 4'hF);
        check("wr_ready", req_ready, 2'b01);
        check("wr_rvalid", req_rvalid, 2'b00);
        tick();
        req_avalid = 2'b00;
        #1;
        check("wr_back_idle", m_avalid, 0);
        check("wr_back_ready", req_ready, 2'b00);

        // Single read from requester 1
        req_addr[1*ADDR_W +: ADDR_W]  = 16'hBFF8;
        req_wstrb[1*STRB_W +: STRB_W] = 4'h0;
        req_avalid = 2'b10;
        tick();
        check("rd_ready", req_ready, 2'b10);
        check("rd_addr", m_addr, 16'hBFF8);
        check("rd_wstrb", m_wstrb, 4'h0);
        tick();
        req_avalid = 2'b00;
        #1;
        check("rd_wait_avalid", m_avalid, 0);
        check("rd_wait_rvalid", req_rvalid, 2'b00);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_0005;
        #1;
        check("rd_rvalid", req_rvalid, 2'b10);
        check("rd_rdata", req_rdata, 32'h0000_0005);
        tick();
        m_rvalid = 1'b0;
        #1;
        check("rd_rvalid_once", req_rvalid, 2'b00);

        // Contention: both requesters hold writes; grants must alternate
        req_wstrb[0*STRB_W +: STRB_W] = 4'hF;
        req_wstrb[1*STRB_W +: STRB_W] = 4'h3;
        req_avalid = 2'b11;
        tick();
        check("cont_gnt0_a", req_ready, 2'b01);
        tick();
        check("cont_idle_a", req_ready, 2'b00);
        tick();
        check("cont_gnt1_a", req_ready, 2'b10);
        check("cont_wstrb1", m_wstrb, 4'h3);
        tick();
        tick();
        check("cont_gnt0_b", req_ready, 2'b01);
        tick();
        tick();
        check("cont_gnt1_b", req_ready, 2'b10);
        tick();
        req_avalid = 2'b00;

        // Abandoned request: req0 drops avalid while ready is low
        m_ready    = 1'b0;
        req_avalid = 2'b01;
        tick();
        check("abd_avalid", m_avalid, 1);
        check("abd_ready", req_ready, 2'b00);
        req_avalid = 2'b00;
        #1;
        check("abd_drop_avalid", m_avalid, 0);
        tick();
        req_avalid = 2'b11;
        m_ready    = 1'b1;
        #1;
        check("abd_idle", m_avalid, 0);
        tick();
        check("abd_ptr_kept", req_ready, 2'b01);
        tick();
        req_avalid = 2'b00;

        // Reset in the middle of a read (pointer now 0, so req1 would win next)
        req_wstrb[1*STRB_W +: STRB_W] = 4'h0;
        req_avalid = 2'b10;
        tick();
        check("mrst_gnt", req_ready, 2'b10);
        tick();
        req_avalid = 2'b00;
        #1;
        check("mrst_wait", req_rvalid, 2'b00);
        arst     = 1'b1;
        m_rvalid = 1'b1;
        #1;
        check("mrst_rvalid", req_rvalid, 2'b00);
        check("mrst_avalid", m_avalid, 0);
        check("mrst_ready", req_ready, 2'b00);
        tick();
        arst = 1'b0;
        tick();
        check("mrst_no_rvalid", req_rvalid, 2'b00);
        m_rvalid   = 1'b0;
        req_wstrb[1*STRB_W +: STRB_W] = 4'hF;
        req_avalid = 2'b11;
        tick();
        check("mrst_first_gnt", req_ready, 2'b01);
        tick();
        req_avalid = 2'b00;

        // Read held without rvalid (pointer 0, so req1 is granted)
        req_wstrb[1*STRB_W +: STRB_W] = 4'h0;
        m_rdata    = 32'hDEAD_BEEF;
        req_avalid = 2'b10;
        tick();
        tick();
        req_avalid = 2'b00;
        #1;
        check("to_wait0", req_rvalid, 2'b00);
`ifdef IOB_CLINT_ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        check("to_rvalid", req_rvalid, 2'b10);
        check("to_rdata", req_rdata, 32'h0);
        check("to_err", err, 1);
        tick();
        check("to_err_pulse", err, 0);
        check("to_rvalid_pulse", req_rvalid, 2'b00);
`else
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (req_rvalid !== 2'b00 || err !== 1'b0) seen = 1'b1;
        end
        check("wait_indefinite", seen, 0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_1234;
        #1;
        check("late_rvalid", req_rvalid, 2'b10);
        check("late_rdata", req_rdata, 32'h0000_1234);
        check("late_err", err, 0);
        tick();
        m_rvalid = 1'b0;
        #1;
        check("late_back_idle", req_rvalid, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
